// File: rtl/cond_flag_reader_if.sv
// ID-stage, flag-register, commit and ID/EX output signals of the NZCV read side.
// The master drives the instruction, flags and commit info; the slave returns stall and EX results.
interface cond_flag_reader_if;
  logic        id_valid;
  logic [3:0]  id_cond;
  logic        id_sets_flags;
  logic        id_is_mrs;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic        cm_valid;
  logic        cm_we;
  logic        cm_n;
  logic        cm_z;
  logic        cm_c;
  logic        cm_v;
  logic        flush;
  logic        ex_ready;
  logic        id_stall;
  logic        ex_valid;
  logic        ex_exec;
  logic        ex_sets_flags;
  logic [31:0] ex_mrs_data;

  modport master (
    output id_valid, id_cond, id_sets_flags, id_is_mrs,
    output flag_n, flag_z, flag_c, flag_v,
    output cm_valid, cm_we, cm_n, cm_z, cm_c, cm_v,
    output flush, ex_ready,
    input  id_stall, ex_valid, ex_exec, ex_sets_flags, ex_mrs_data
  );

  modport slave (
    input  id_valid, id_cond, id_sets_flags, id_is_mrs,
    input  flag_n, flag_z, flag_c, flag_v,
    input  cm_valid, cm_we, cm_n, cm_z, cm_c, cm_v,
    input  flush, ex_ready,
    output id_stall, ex_valid, ex_exec, ex_sets_flags, ex_mrs_data
  );
endinterface

// File: rtl/cond_flag_reader.sv
// NZCV read side between ID and EX: condition evaluation, MRS value, flag-writer
// hazard tracking with commit bypass, and a registered ready/valid ID/EX stage.
module cond_flag_reader #(
  parameter int MAX_PENDING = 3,
  parameter int CNT_W       = 2
) (
  input logic               clk,
  input logic               rst,
  cond_flag_reader_if.slave bus
);
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [CNT_W-1:0] pending_reg;
  logic [CNT_W-1:0] pending_next;
  logic [CNT_W-1:0] pending_after;
  logic             ex_valid_reg;
  logic             ex_exec_reg;
  logic             ex_sets_flags_reg;
  logic [31:0]      ex_mrs_data_reg;

  logic [3:0]  flags_eff;
  logic        fn, fz, fc, fv;
  logic        cond_pass;
  logic        needs_flags;
  logic        hazard;
  logic        full_stall;
  logic        bp_stall;
  logic        stall;
  logic        issue;
  logic        cnt_inc;
  logic        cnt_dec;
  logic [31:0] mrs_word;

  // A flag update retiring this cycle is forwarded straight into evaluation.
  assign flags_eff = (bus.cm_valid && bus.cm_we) ? {bus.cm_n, bus.cm_z, bus.cm_c, bus.cm_v}
                                                 : {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
  assign {fn, fz, fc, fv} = flags_eff;

  always_comb begin
    cond_pass = 1'b0;
    case (bus.id_cond)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc && !fz;
      4'h9: cond_pass = !fc || fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = !fz && (fn == fv);
      4'hD: cond_pass = fz || (fn != fv);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_mrs
      if (gi < 4) begin : g_flag
        assign mrs_word[gi] = flags_eff[gi];
      end else begin : g_zero
        assign mrs_word[gi] = 1'b0;
      end
    end
  endgenerate

  // A commit seen with nothing pending is ignored so the counter cannot wrap.
  assign cnt_dec       = bus.cm_valid && (pending_reg != '0);
  assign pending_after = cnt_dec ? (pending_reg - PEND_ONE) : pending_reg;

  assign needs_flags = (bus.id_cond != 4'hE) || bus.id_is_mrs;
  assign hazard      = needs_flags && (pending_after != '0);
  assign full_stall  = bus.id_sets_flags && (pending_reg == PEND_MAX) && !bus.cm_valid;
  assign bp_stall    = ex_valid_reg && !bus.ex_ready;
  assign stall       = bus.id_valid && (hazard || full_stall || bp_stall);
  assign issue       = bus.id_valid && !stall && !bus.flush;
  assign cnt_inc     = issue && bus.id_sets_flags;

  always_comb begin
    pending_next = pending_reg;
    case ({cnt_inc, cnt_dec})
      2'b10:   pending_next = pending_reg + PEND_ONE;
      2'b01:   pending_next = pending_reg - PEND_ONE;
      default: pending_next = pending_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg       <= '0;
      ex_valid_reg      <= 1'b0;
      ex_exec_reg       <= 1'b0;
      ex_sets_flags_reg <= 1'b0;
      ex_mrs_data_reg   <= '0;
    end else begin
      pending_reg <= pending_next;
      if (bus.flush || (ex_valid_reg && bus.ex_ready && !issue)) begin
        ex_valid_reg      <= 1'b0;
        ex_exec_reg       <= 1'b0;
        ex_sets_flags_reg <= 1'b0;
        ex_mrs_data_reg   <= '0;
      end else if (issue && (!ex_valid_reg || bus.ex_ready)) begin
        ex_valid_reg      <= 1'b1;
        ex_exec_reg       <= cond_pass;
        ex_sets_flags_reg <= bus.id_sets_flags && cond_pass;
        ex_mrs_data_reg   <= (bus.id_is_mrs && cond_pass) ? mrs_word : 32'h0;
      end
    end
  end

  assign bus.id_stall      = stall;
  assign bus.ex_valid      = ex_valid_reg;
  assign bus.ex_exec       = ex_exec_reg;
  assign bus.ex_sets_flags = ex_sets_flags_reg;
  assign bus.ex_mrs_data   = ex_mrs_data_reg;
endmodule

// File: tb/tb_cond_flag_reader.sv
// Directed and randomized checks of cond_flag_reader against a cycle-level
// behavioural model of the flag read side.
module tb_cond_flag_reader;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  cond_flag_reader_if bus();

  cond_flag_reader #(.MAX_PENDING(3), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_pending;
  bit          m_ex_valid;
  bit          m_ex_exec;
  bit          m_ex_sets;
  logic [31:0] m_ex_mrs;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Conditions come in pairs: odd codes are the negation of the even base.
  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [3:0] eff_flags();
    if (bus.cm_valid && bus.cm_we) return {bus.cm_n, bus.cm_z, bus.cm_c, bus.cm_v};
    return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
  endfunction

  function automatic bit model_stall();
    int after;
    bit needs;
    needs = (bus.id_cond != 4'hE) || bus.id_is_mrs;
    after = m_pending - (bus.cm_valid ? 1 : 0);
    if (after < 0) after = 0;
    return bus.id_valid && ((needs && after != 0) ||
                            (bus.id_sets_flags && m_pending == 3 && !bus.cm_valid) ||
                            (m_ex_valid && !bus.ex_ready));
  endfunction

  task automatic idle();
    bus.id_valid = 0; bus.id_cond = 4'hE; bus.id_sets_flags = 0; bus.id_is_mrs = 0;
    bus.flag_n = 0; bus.flag_z = 0; bus.flag_c = 0; bus.flag_v = 0;
    bus.cm_valid = 0; bus.cm_we = 0; bus.cm_n = 0; bus.cm_z = 0; bus.cm_c = 0; bus.cm_v = 0;
    bus.flush = 0; bus.ex_ready = 1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock of the transaction currently on the inputs, checked against the model.
  task automatic step(string tag);
    bit exp_stall, exp_issue, pass;
    logic [3:0] f;
    f = eff_flags();
    exp_stall = model_stall();
    exp_issue = bus.id_valid && !exp_stall && !bus.flush;
    pass = cond_ok(bus.id_cond, f);
    #1;
    check({tag, "_stall"}, 32'(bus.id_stall), 32'(exp_stall));
    @(posedge clk);
    if (rst) begin
      m_pending = 0; m_ex_valid = 0; m_ex_exec = 0; m_ex_sets = 0; m_ex_mrs = 0;
    end else begin
      if (bus.cm_valid && m_pending > 0) m_pending--;
      if (exp_issue && bus.id_sets_flags) m_pending++;
      if (bus.flush || (m_ex_valid && bus.ex_ready && !exp_issue)) begin
        m_ex_valid = 0; m_ex_exec = 0; m_ex_sets = 0; m_ex_mrs = 0;
      end else if (exp_issue) begin
        m_ex_valid = 1;
        m_ex_exec  = pass;
        m_ex_sets  = bus.id_sets_flags && pass;
        m_ex_mrs   = (bus.id_is_mrs && pass) ? {28'h0, f} : 32'h0;
      end
    end
    #1;
    check({tag, "_valid"}, 32'(bus.ex_valid), 32'(m_ex_valid));
    check({tag, "_exec"}, 32'(bus.ex_exec), 32'(m_ex_exec));
    check({tag, "_sets"}, 32'(bus.ex_sets_flags), 32'(m_ex_sets));
    check({tag, "_mrs"}, bus.ex_mrs_data, m_ex_mrs);
    $display("%0t %s rst=%0b v=%0b cond=%0h s=%0b mrs=%0b cm=%0b fl=%0b rdy=%0b | stall_exp=%0b ex_valid=%0b exec=%0b data=%0h",
             $time, tag, rst, bus.id_valid, bus.id_cond, bus.id_sets_flags, bus.id_is_mrs,
             bus.cm_valid, bus.flush, bus.ex_ready, exp_stall, bus.ex_valid, bus.ex_exec,
             bus.ex_mrs_data);
  endtask

  bit exp_tab [16] = '{1,0,1,0,0,1,0,1,0,1,1,0,0,1,1,0};

  initial begin
    m_pending = 0; m_ex_valid = 0; m_ex_exec = 0; m_ex_sets = 0; m_ex_mrs = 0;
    idle();
    rst = 1;
    bus.id_valid = 1; bus.id_cond = 4'h0;
    @(posedge clk); #1;
    step("rst0");
    step("rst1");
    rst = 0;
    idle();
    settle();
    check("rst_stall", 32'(bus.id_stall), 32'd0);
    check("rst_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_data", bus.ex_mrs_data, 32'd0);

    // Condition table with Z=1, C=1
    bus.flag_z = 1; bus.flag_c = 1;
    for (int c = 0; c < 16; c++) begin
      bus.id_valid = 1; bus.id_cond = 4'(c);
      step("ctab");
      check($sformatf("ctab_%0h", c), 32'(bus.ex_exec), 32'(exp_tab[c]));
    end

    // Hazard and commit bypass
    idle();
    bus.id_valid = 1; bus.id_cond = 4'hE; bus.id_sets_flags = 1;
    step("adds");
    bus.id_cond = 4'h0; bus.id_sets_flags = 0;
    settle();
    check("hz_stall_on", 32'(bus.id_stall), 32'd1);
    step("beq_wait");
    bus.cm_valid = 1; bus.cm_we = 1; bus.cm_z = 1;
    settle();
    check("hz_bypass", 32'(bus.id_stall), 32'd0);
    step("beq_byp");
    check("hz_exec", 32'(bus.ex_exec), 32'd1);
    bus.cm_valid = 0; bus.cm_we = 0; bus.cm_z = 0;
    settle();
    check("hz_drained", 32'(bus.id_stall), 32'd0);
    step("beq_again");

    // MRS
    idle();
    bus.flag_n = 1; bus.flag_v = 1;
    bus.id_valid = 1; bus.id_is_mrs = 1;
    step("mrs");
    check("mrs_data", bus.ex_mrs_data, 32'h0000_0009);
    bus.id_is_mrs = 0; bus.id_sets_flags = 1;
    step("mrs_wr");
    bus.id_is_mrs = 1; bus.id_sets_flags = 0;
    settle();
    check("mrs_stall", 32'(bus.id_stall), 32'd1);
    step("mrs_wait");
    bus.cm_valid = 1;
    settle();
    check("mrs_release", 32'(bus.id_stall), 32'd0);
    step("mrs_go");
    check("mrs_data2", bus.ex_mrs_data, 32'h0000_0009);

    // Counter limit
    idle();
    bus.id_valid = 1; bus.id_sets_flags = 1;
    for (int k = 0; k < 3; k++) step("cnt_wr");
    settle();
    check("cnt_full", 32'(bus.id_stall), 32'd1);
    step("cnt_blk");
    bus.cm_valid = 1; bus.cm_we = 1;
    settle();
    check("cnt_swap", 32'(bus.id_stall), 32'd0);
    step("cnt_swap");
    bus.cm_valid = 0; bus.cm_we = 0;
    settle();
    check("cnt_full2", 32'(bus.id_stall), 32'd1);
    step("cnt_blk2");
    bus.id_valid = 0; bus.cm_valid = 1;
    for (int k = 0; k < 4; k++) step("cnt_drain");
    bus.cm_valid = 0; bus.id_valid = 1; bus.id_sets_flags = 0; bus.id_cond = 4'h0;
    settle();
    check("cnt_nowrap", 32'(bus.id_stall), 32'd0);
    step("cnt_nowrap");

    // Backpressure and flush
    idle();
    step("bp_drain");
    bus.ex_ready = 0; bus.id_valid = 1; bus.id_sets_flags = 1;
    step("bp_load");
    bus.id_sets_flags = 0; bus.id_cond = 4'h1;
    settle();
    check("bp_stall", 32'(bus.id_stall), 32'd1);
    step("bp_hold");
    check("bp_held", 32'(bus.ex_sets_flags), 32'd1);
    bus.flush = 1;
    step("flush");
    check("fl_clear", 32'(bus.ex_valid), 32'd0);
    bus.flush = 0; bus.ex_ready = 1; bus.id_cond = 4'h0;
    settle();
    check("fl_pend_kept", 32'(bus.id_stall), 32'd1);
    step("fl_wait");
    bus.id_valid = 0; bus.cm_valid = 1;
    step("fl_commit");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst               = ($urandom_range(0, 199) == 0);
      bus.id_valid      = ($urandom_range(0, 3) != 0);
      bus.id_cond       = 4'($urandom);
      bus.id_sets_flags = ($urandom_range(0, 2) == 0);
      bus.id_is_mrs     = ($urandom_range(0, 3) == 0);
      {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v} = 4'($urandom);
      bus.cm_valid      = (m_pending > 0) && ($urandom_range(0, 2) == 0);
      bus.cm_we         = 1'($urandom);
      {bus.cm_n, bus.cm_z, bus.cm_c, bus.cm_v} = 4'($urandom);
      bus.flush         = ($urandom_range(0, 15) == 0);
      bus.ex_ready      = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
